// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply/divide responder for the multicycle CPU.
// A one-cycle start pulse in IDLE latches op/src_a/src_b. MULT runs radix-2 Booth and
// DIV runs restoring division on magnitudes, one step per cycle for DATA_W cycles. One
// further RUN cycle applies sign fixes and loads hi_out/lo_out. done then pulses for one
// cycle in FINISH.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start, op           request pulse (IDLE only); 0 = MULT, 1 = DIV (both signed)
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   busy                high whenever the unit is not idle
//   done, div_zero      one-cycle result pulse; div_zero marks DIV by zero
//   hi_out, lo_out      MULT: product high/low; DIV: remainder/quotient
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic              is_div;
  // acc has one guard bit so Booth add/subtract of the most negative multiplicand
  // cannot overflow, and the restoring shift can hold up to 2*divisor-1.
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] qreg;
  logic [DATA_W-1:0] mcand;
  logic              qm1;
  logic              neg_q;
  logic              neg_r;

  logic [DATA_W:0]   acc_next;
  logic [DATA_W-1:0] qreg_next;
  logic              qm1_next;
  logic [DATA_W:0]   booth_sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   trial;

  // Unsigned magnitude; the most negative value maps to itself, which is its
  // correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (-v) : v;
  endfunction

  // One Booth step or one restoring-division step, selected by the latched op.
  always_comb begin
    booth_sum = acc;
    rem_sh    = acc;
    trial     = acc;
    acc_next  = acc;
    qreg_next = qreg;
    qm1_next  = qm1;
    if (is_div) begin
      rem_sh = {acc[DATA_W-1:0], qreg[DATA_W-1]};
      trial  = rem_sh - {1'b0, mcand};
      if (trial[DATA_W]) begin
        acc_next  = rem_sh;
        qreg_next = {qreg[DATA_W-2:0], 1'b0};
      end else begin
        acc_next  = trial;
        qreg_next = {qreg[DATA_W-2:0], 1'b1};
      end
      qm1_next = 1'b0;
    end else begin
      case ({qreg[0], qm1})
        2'b01:   booth_sum = acc + {mcand[DATA_W-1], mcand};
        2'b10:   booth_sum = acc - {mcand[DATA_W-1], mcand};
        default: booth_sum = acc;
      endcase
      // Arithmetic right shift of {acc, qreg, qm1}.
      acc_next  = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
      qreg_next = {booth_sum[0], qreg[DATA_W-1:1]};
      qm1_next  = qreg[0];
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      acc      <= '0;
      qreg     <= '0;
      mcand    <= '0;
      qm1      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            is_div <= op;
            count  <= '0;
            acc    <= '0;
            qm1    <= 1'b0;
            busy   <= 1'b1;
            if (op) begin
              qreg  <= magnitude(src_a);
              mcand <= magnitude(src_b);
              neg_q <= src_a[DATA_W-1] ^ src_b[DATA_W-1];
              neg_r <= src_a[DATA_W-1];
              if (src_b == '0) begin
                // Divide by zero skips RUN; hi_out/lo_out keep their values.
                state    <= FINISH;
                done     <= 1'b1;
                div_zero <= 1'b1;
              end else begin
                state <= RUN;
              end
            end else begin
              qreg  <= src_b;
              mcand <= src_a;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= RUN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (count == CNT_W'(DATA_W)) begin
            // All steps are done: apply sign fixes and publish the result.
            if (is_div) begin
              hi_out <= neg_r ? (-acc[DATA_W-1:0]) : acc[DATA_W-1:0];
              lo_out <= neg_q ? (-qreg) : qreg;
            end else begin
              hi_out <= acc[DATA_W-1:0];
              lo_out <= qreg;
            end
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            acc   <= acc_next;
            qreg  <= qreg_next;
            qm1   <= qm1_next;
            count <= count + CNT_W'(1);
          end
        end
        FINISH: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
